// File: rtl/exu_lsu_queue.sv
// Execute-stage load/store unit: address generation, alignment check, store lane
// formatting, valid/grant bus request and an in-order queue of outstanding loads.
module exu_lsu_queue #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int LQ_DEPTH = 4,
    parameter int RD_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid_i,
    output logic                  issue_ready_o,
    input  logic                  issue_store_i,
    input  logic [2:0]            issue_funct3_i,
    input  logic [ADDR_W-1:0]     issue_base_i,
    input  logic [ADDR_W-1:0]     issue_offset_i,
    input  logic [DATA_W-1:0]     issue_wdata_i,
    input  logic [RD_W-1:0]       issue_rd_i,
    input  logic                  flush_i,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    output logic [DATA_W/8-1:0]   mem_wstrb_o,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    output logic                  reg_we_o,
    output logic [RD_W-1:0]       reg_waddr_o,
    output logic [DATA_W-1:0]     reg_wdata_o,
    output logic                  exc_valid_o,
    output logic                  exc_store_o,
    output logic [ADDR_W-1:0]     exc_addr_o,
    output logic                  lq_busy_o
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_W = $clog2(STRB_W);
    localparam int PTR_W  = $clog2(LQ_DEPTH);

    logic [ADDR_W-1:0] ea;
    logic [LANE_W-1:0] lane;
    logic [2:0]        align_mask;
    logic [STRB_W-1:0] size_mask;
    logic [STRB_W-1:0] strb;
    logic [DATA_W-1:0] store_data;
    logic              supported;
    logic              misaligned;

    assign ea   = issue_base_i + issue_offset_i;
    assign lane = ea[LANE_W-1:0];

    always_comb begin
        supported = 1'b1;
        if (issue_store_i) begin
            supported = !issue_funct3_i[2] && ((issue_funct3_i[1:0] != 2'd3) || (DATA_W == 64));
        end else begin
            case (issue_funct3_i)
                3'b011, 3'b110: supported = (DATA_W == 64);
                3'b111:         supported = 1'b0;
                default:        supported = 1'b1;
            endcase
        end
    end

    always_comb begin
        case (issue_funct3_i[1:0])
            2'd0:    begin align_mask = 3'b000; size_mask = STRB_W'(1);  end
            2'd1:    begin align_mask = 3'b001; size_mask = STRB_W'(3);  end
            2'd2:    begin align_mask = 3'b011; size_mask = STRB_W'(15); end
            default: begin align_mask = 3'b111; size_mask = '1;          end
        endcase
    end

    assign misaligned = !supported || ((ea[2:0] & align_mask) != 3'b000);
    assign strb       = size_mask << lane;

    // Each selected lane takes rs2 byte (lane mod size), i.e. the low bytes replicated.
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
        logic [2:0] src;
        assign src = 3'(gi) & align_mask & 3'(STRB_W - 1);
        assign store_data[gi*8 +: 8] = strb[gi] ? 8'(issue_wdata_i >> {src, 3'b000}) : 8'h00;
    end

    // Load queue state
    logic [PTR_W:0]    wr_ptr_reg, rd_ptr_reg;
    logic [RD_W-1:0]   rd_mem  [LQ_DEPTH];
    logic [2:0]        f3_mem  [LQ_DEPTH];
    logic [LANE_W-1:0] off_mem [LQ_DEPTH];
    logic [LQ_DEPTH-1:0] kill_reg;
    logic              lq_full, lq_empty, push, pop;
    logic [PTR_W-1:0]  wr_idx, head_idx;

    assign wr_idx   = wr_ptr_reg[PTR_W-1:0];
    assign head_idx = rd_ptr_reg[PTR_W-1:0];
    assign lq_empty = (wr_ptr_reg == rd_ptr_reg);
    assign lq_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) && (wr_idx == head_idx);
    assign lq_busy_o = !lq_empty;

    always_comb begin
        mem_req_o     = 1'b0;
        issue_ready_o = 1'b0;
        if (issue_valid_i) begin
            if (flush_i || misaligned) begin
                issue_ready_o = 1'b1;
            end else if (issue_store_i) begin
                mem_req_o     = 1'b1;
                issue_ready_o = mem_gnt_i;
            end else begin
                mem_req_o     = !lq_full;
                issue_ready_o = mem_gnt_i && !lq_full;
            end
        end
    end

    assign mem_we_o    = mem_req_o && issue_store_i;
    assign mem_addr_o  = mem_req_o ? {ea[ADDR_W-1:LANE_W], {LANE_W{1'b0}}} : '0;
    assign mem_wstrb_o = mem_we_o ? strb : '0;
    assign mem_wdata_o = mem_we_o ? store_data : '0;

    assign push = mem_req_o && mem_gnt_i && !issue_store_i;
    assign pop  = mem_rvalid_i && !lq_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            kill_reg   <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            // Free slots may be marked too; a push always rewrites its slot's kill bit.
            for (int i = 0; i < LQ_DEPTH; i++) begin
                if (flush_i) kill_reg[i] <= 1'b1;
                else if (push && (wr_idx == PTR_W'(i))) kill_reg[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_idx]  <= issue_rd_i;
            f3_mem[wr_idx]  <= issue_funct3_i;
            off_mem[wr_idx] <= lane;
        end
    end

    // Response formatting: shift the addressed lane down, then sign/zero extend.
    logic [2:0]               head_f3;
    logic [6:0]               sh_amt;
    logic [DATA_W-1:0]        lane_data, left_data, load_data;
    logic signed [DATA_W-1:0] left_s, sext_data;

    assign head_f3 = f3_mem[head_idx];

    always_comb begin
        case (head_f3[1:0])
            2'd0:    sh_amt = 7'(DATA_W - 8);
            2'd1:    sh_amt = 7'(DATA_W - 16);
            2'd2:    sh_amt = 7'(DATA_W - 32);
            default: sh_amt = 7'd0;
        endcase
        lane_data = mem_rdata_i >> {off_mem[head_idx], 3'b000};
        left_data = lane_data << sh_amt;
        left_s    = left_data;
        sext_data = left_s >>> sh_amt;
        load_data = head_f3[2] ? (left_data >> sh_amt) : sext_data;
    end

    logic              reg_we_reg, exc_valid_reg, exc_store_reg, wb_fire, exc_fire;
    logic [RD_W-1:0]   reg_waddr_reg;
    logic [DATA_W-1:0] reg_wdata_reg;
    logic [ADDR_W-1:0] exc_addr_reg;

    assign wb_fire  = pop && !kill_reg[head_idx] && !flush_i;
    assign exc_fire = issue_valid_i && !flush_i && misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_we_reg    <= 1'b0;
            reg_waddr_reg <= '0;
            reg_wdata_reg <= '0;
            exc_valid_reg <= 1'b0;
            exc_store_reg <= 1'b0;
            exc_addr_reg  <= '0;
        end else begin
            reg_we_reg    <= wb_fire;
            exc_valid_reg <= exc_fire;
            if (wb_fire) begin
                reg_waddr_reg <= rd_mem[head_idx];
                reg_wdata_reg <= load_data;
            end
            if (exc_fire) begin
                exc_store_reg <= issue_store_i;
                exc_addr_reg  <= ea;
            end
        end
    end

    assign reg_we_o    = reg_we_reg;
    assign reg_waddr_o = reg_waddr_reg;
    assign reg_wdata_o = reg_wdata_reg;
    assign exc_valid_o = exc_valid_reg;
    assign exc_store_o = exc_store_reg;
    assign exc_addr_o  = exc_addr_reg;
endmodule

// File: tb/tb_exu_lsu_queue.sv
// Bench for exu_lsu_queue: 32-bit and 64-bit instances, vector table, directed
// multi-cycle sequences and a randomized run against a queue-based reference model.
module tb_exu_lsu_queue;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        v32, v64, store, flush, gnt, rv32, rv64;
    logic [2:0]  f3;
    logic [31:0] base, off;
    logic [63:0] wdata, rdata;
    logic [4:0]  rd;

    logic        rdy32, req32, we32, regwe32, exc32, excs32, busy32;
    logic [31:0] addr32, mwd32, wd32, exca32;
    logic [3:0]  strb32;
    logic [4:0]  wa32;

    logic        rdy64, req64, we64, regwe64, exc64, excs64, busy64;
    logic [31:0] addr64, exca64;
    logic [63:0] mwd64, wd64;
    logic [7:0]  strb64;
    logic [4:0]  wa64;

    exu_lsu_queue #(.DATA_W(32), .ADDR_W(32), .LQ_DEPTH(4), .RD_W(5)) dut32 (
        .clk(clk), .rst(rst),
        .issue_valid_i(v32), .issue_ready_o(rdy32), .issue_store_i(store),
        .issue_funct3_i(f3), .issue_base_i(base), .issue_offset_i(off),
        .issue_wdata_i(wdata[31:0]), .issue_rd_i(rd), .flush_i(flush),
        .mem_req_o(req32), .mem_gnt_i(gnt), .mem_we_o(we32), .mem_addr_o(addr32),
        .mem_wdata_o(mwd32), .mem_wstrb_o(strb32),
        .mem_rvalid_i(rv32), .mem_rdata_i(rdata[31:0]),
        .reg_we_o(regwe32), .reg_waddr_o(wa32), .reg_wdata_o(wd32),
        .exc_valid_o(exc32), .exc_store_o(excs32), .exc_addr_o(exca32),
        .lq_busy_o(busy32)
    );

    exu_lsu_queue #(.DATA_W(64), .ADDR_W(32), .LQ_DEPTH(4), .RD_W(5)) dut64 (
        .clk(clk), .rst(rst),
        .issue_valid_i(v64), .issue_ready_o(rdy64), .issue_store_i(store),
        .issue_funct3_i(f3), .issue_base_i(base), .issue_offset_i(off),
        .issue_wdata_i(wdata), .issue_rd_i(rd), .flush_i(flush),
        .mem_req_o(req64), .mem_gnt_i(gnt), .mem_we_o(we64), .mem_addr_o(addr64),
        .mem_wdata_o(mwd64), .mem_wstrb_o(strb64),
        .mem_rvalid_i(rv64), .mem_rdata_i(rdata),
        .reg_we_o(regwe64), .reg_waddr_o(wa64), .reg_wdata_o(wd64),
        .exc_valid_o(exc64), .exc_store_o(excs64), .exc_addr_o(exca64),
        .lq_busy_o(busy64)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        v32 = 0; v64 = 0; store = 0; f3 = 0; base = 0; off = 0; wdata = 0;
        rd = 0; flush = 0; gnt = 0; rv32 = 0; rv64 = 0; rdata = 0;
    endtask

    // Grant in T, response in T+2, writeback checked in T+3.
    task automatic load_seq(input bit wide, input logic [2:0] lf3, input logic [31:0] ea,
                            input logic [4:0] lrd, input logic [63:0] rsp, input logic [63:0] exp,
                            input string name);
        idle();
        if (wide) v64 = 1; else v32 = 1;
        f3 = lf3; base = ea; rd = lrd; gnt = 1;
        @(negedge clk);
        check({name, " req"},   wide ? req64 : req32, 1);
        check({name, " ready"}, wide ? rdy64 : rdy32, 1);
        check({name, " addr"},  wide ? addr64 : addr32, wide ? (ea & ~32'h7) : (ea & ~32'h3));
        step(); idle();
        @(negedge clk);
        step();
        if (wide) rv64 = 1; else rv32 = 1;
        rdata = rsp;
        @(negedge clk);
        step(); idle();
        @(negedge clk);
        check({name, " reg_we"},    wide ? regwe64 : regwe32, 1);
        check({name, " reg_waddr"}, wide ? wa64 : wa32, lrd);
        check({name, " reg_wdata"}, wide ? wd64 : {32'b0, wd32}, exp);
        check({name, " busy"},      wide ? busy64 : busy32, 0);
        $display("%s: ea=0x%0h rd=%0d rdata=0x%0h wdata=0x%0h", name, ea, lrd, rsp,
                 wide ? wd64 : {32'b0, wd32});
        step();
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] base, off, wd;
        logic        gnt, flush;
        logic        req, rdy;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] mwd;
        logic        we, exc;
    } vec_t;

    typedef struct {
        logic [4:0] rd;
        logic [2:0] f3;
        logic [1:0] off;
        bit         kill;
    } lq_ent_t;

    function automatic logic [31:0] ref_load(input logic [31:0] rdv, input logic [2:0] lf3,
                                             input logic [1:0] loff);
        longint unsigned v, m;
        int bits;
        bits = 8 << lf3[1:0];
        v = 64'(rdv) >> (8 * loff);
        if (bits < 32) begin
            m = (64'd1 << bits) - 1;
            v = v & m;
            if (!lf3[2] && (((v >> (bits - 1)) & 1) == 1)) v = v | ~m;
        end
        return v[31:0];
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks_total);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t    vecs[12];
        lq_ent_t mq[$];
        int      exp_rd[4];
        logic    e_we, e_exc, e_excs;
        logic [4:0]  e_wa;
        logic [31:0] e_wd, e_exca;

        vecs[0]  = '{1'b1, 3'd0, 32'h200, 32'h1, 32'hAB,       1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 4'b0010, 32'h0000AB00, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 3'd1, 32'h200, 32'h2, 32'h1234,     1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 4'b1100, 32'h12340000, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 3'd2, 32'h300, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h300, 4'b1111, 32'hDEADBEEF, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 3'd2, 32'h100, 32'h2, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b1};
        vecs[4]  = '{1'b0, 3'd1, 32'h100, 32'h4, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h104, 4'b0000, 32'h0,        1'b0, 1'b0};
        vecs[5]  = '{1'b1, 3'd3, 32'h400, 32'h0, 32'h55,       1'b1, 1'b0, 1'b0, 1'b1, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b1};
        vecs[6]  = '{1'b1, 3'd2, 32'h500, 32'h0, 32'h77,       1'b1, 1'b1, 1'b0, 1'b1, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b0};
        vecs[7]  = '{1'b0, 3'd0, 32'hFFFFFFFF, 32'h2, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b0};
        vecs[8]  = '{1'b1, 3'd0, 32'h0,   32'h3, 32'h11223344, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0,   4'b1000, 32'h44000000, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 3'd7, 32'h100, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b1};
        vecs[10] = '{1'b0, 3'd2, 32'h101, 32'h0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b0};
        vecs[11] = '{1'b1, 3'd1, 32'h203, 32'h0, 32'h9999,     1'b1, 1'b0, 1'b0, 1'b1, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b1};

        // Reset state
        rst = 1; idle();
        step(); step();
        @(negedge clk);
        check("rst req", req32, 0);       check("rst ready", rdy32, 0);
        check("rst reg_we", regwe32, 0);  check("rst reg_waddr", wa32, 0);
        check("rst reg_wdata", wd32, 0);  check("rst exc_valid", exc32, 0);
        check("rst exc_store", excs32, 0); check("rst exc_addr", exca32, 0);
        check("rst busy", busy32, 0);     check("rst busy64", busy64, 0);
        step(); rst = 0;
        step();

        // Issue-path vector table
        foreach (vecs[i]) begin
            idle();
            v32 = 1; store = vecs[i].st; f3 = vecs[i].f3; base = vecs[i].base; off = vecs[i].off;
            wdata = {32'b0, vecs[i].wd}; gnt = vecs[i].gnt; flush = vecs[i].flush;
            @(negedge clk);
            check($sformatf("vec%0d req", i),   req32,  vecs[i].req);
            check($sformatf("vec%0d ready", i), rdy32,  vecs[i].rdy);
            check($sformatf("vec%0d addr", i),  addr32, vecs[i].addr);
            check($sformatf("vec%0d wstrb", i), strb32, vecs[i].strb);
            check($sformatf("vec%0d wdata", i), mwd32,  vecs[i].mwd);
            check($sformatf("vec%0d we", i),    we32,   vecs[i].we);
            $display("vec%0d: st=%0d f3=%0d ea=0x%0h req=%0d ready=%0d strb=%b", i, vecs[i].st,
                     vecs[i].f3, vecs[i].base + vecs[i].off, req32, rdy32, strb32);
            step(); idle();
            @(negedge clk);
            check($sformatf("vec%0d exc_valid", i), exc32, vecs[i].exc);
            if (vecs[i].exc) begin
                check($sformatf("vec%0d exc_addr", i),  exca32, vecs[i].base + vecs[i].off);
                check($sformatf("vec%0d exc_store", i), excs32, vecs[i].st);
            end
            step();
            @(negedge clk);
            check($sformatf("vec%0d exc_pulse", i), exc32, 0);
            step();
        end

        // Load formatting, 32-bit
        load_seq(0, 3'd2, 32'h100, 5'd5, 64'h80FF1234, 64'h80FF1234, "lw");
        load_seq(0, 3'd0, 32'h103, 5'd7, 64'h80FF1234, 64'hFFFFFF80, "lb");
        load_seq(0, 3'd5, 32'h102, 5'd8, 64'h80FF1234, 64'h000080FF, "lhu");

        // Queue full, no bypass on pop
        idle();
        for (int i = 0; i < 4; i++) begin
            v32 = 1; f3 = 3'd2; base = 32'h40 * (i + 1); rd = 5'(i + 1); gnt = 1;
            @(negedge clk);
            check($sformatf("full fill%0d ready", i), rdy32, 1);
            $display("full: load %0d issued rd=%0d", i, i + 1);
            step();
        end
        rd = 5'd9; base = 32'h180;
        @(negedge clk);
        check("full 5th req", req32, 0);
        check("full 5th ready", rdy32, 0);
        check("full busy", busy32, 1);
        step();
        rv32 = 1; rdata = 64'hA1;
        @(negedge clk);
        check("full pop-cycle req", req32, 0);
        check("full pop-cycle ready", rdy32, 0);
        step();
        rv32 = 0;
        @(negedge clk);
        check("full 5th req after pop", req32, 1);
        check("full 5th ready after pop", rdy32, 1);
        check("full wb0 we", regwe32, 1);
        check("full wb0 waddr", wa32, 1);
        check("full wb0 wdata", wd32, 32'hA1);
        step(); idle();
        exp_rd = '{2, 3, 4, 9};
        for (int i = 0; i < 4; i++) begin
            rv32 = 1; rdata = 64'(32'hB0 + i);
            @(negedge clk);
            step(); rv32 = 0;
            @(negedge clk);
            check($sformatf("drain%0d we", i), regwe32, 1);
            check($sformatf("drain%0d waddr", i), wa32, 5'(exp_rd[i]));
            check($sformatf("drain%0d wdata", i), wd32, 32'hB0 + i);
            $display("drain: rd=%0d wdata=0x%0h", wa32, wd32);
            step();
        end
        @(negedge clk);
        check("drain busy", busy32, 0);
        step();

        // Flush kills outstanding loads
        for (int i = 0; i < 3; i++) begin
            v32 = 1; f3 = 3'd2; base = 32'h600 + 32'(4 * i); rd = 5'(10 + i); gnt = 1;
            @(negedge clk);
            check($sformatf("flush fill%0d ready", i), rdy32, 1);
            step();
        end
        flush = 1;
        @(negedge clk);
        check("flush req", req32, 0);
        check("flush ready", rdy32, 1);
        step(); idle();
        for (int i = 0; i < 3; i++) begin
            rv32 = 1; rdata = 64'($urandom);
            @(negedge clk);
            check($sformatf("flush rsp%0d no we", i), regwe32, 0);
            step();
        end
        rv32 = 0;
        @(negedge clk);
        check("flush last no we", regwe32, 0);
        check("flush busy", busy32, 0);
        $display("flush: three killed responses drained");
        step();
        load_seq(0, 3'd2, 32'h700, 5'd13, 64'h12345678, 64'h12345678, "post-flush lw");

        // Reset mid-operation
        for (int i = 0; i < 2; i++) begin
            v32 = 1; f3 = 3'd2; base = 32'h800 + 32'(4 * i); rd = 5'(20 + i); gnt = 1;
            step();
        end
        idle(); rst = 1;
        step(); rst = 0;
        @(negedge clk);
        check("midrst busy", busy32, 0);
        check("midrst we", regwe32, 0);
        step();
        rv32 = 1; rdata = 64'h5A5A5A5A;
        step(); rv32 = 0;
        @(negedge clk);
        check("midrst spurious we", regwe32, 0);
        check("midrst spurious busy", busy32, 0);
        step();
        load_seq(0, 3'd4, 32'h901, 5'd22, 64'h0000F000, 64'h000000F0, "post-reset lbu");

        // 64-bit instance
        load_seq(1, 3'd3, 32'h8, 5'd3, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, "ld64");
        load_seq(1, 3'd6, 32'h4, 5'd4, 64'hFFFFFFFF00000000, 64'h00000000FFFFFFFF, "lwu64");
        load_seq(1, 3'd2, 32'h4, 5'd6, 64'hFFFFFFFF00000000, 64'hFFFFFFFFFFFFFFFF, "lw64");
        load_seq(1, 3'd5, 32'h6, 5'd8, 64'h1234800000000000, 64'h0000000000001234, "lhu64");
        idle();
        v64 = 1; store = 1; f3 = 3'd2; base = 32'hC; wdata = 64'hCAFEBABE; gnt = 1;
        @(negedge clk);
        check("sw64 addr", addr64, 32'h8);
        check("sw64 wstrb", strb64, 8'hF0);
        check("sw64 wdata", mwd64, 64'hCAFEBABE00000000);
        step();
        f3 = 3'd3; base = 32'h10; wdata = 64'h1122334455667788;
        @(negedge clk);
        check("sd64 wstrb", strb64, 8'hFF);
        check("sd64 wdata", mwd64, 64'h1122334455667788);
        $display("store64: sd addr=0x%0h strb=%b", addr64, strb64);
        step(); idle();
        step();

        // Randomized run against the reference model
        e_we = 0; e_exc = 0; e_excs = 0; e_wa = 0; e_wd = 0; e_exca = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            logic [31:0] ea, e_mwd;
            logic [3:0]  e_strb;
            int          sz, ln;
            bit          sup, mis, e_req, e_rdy;
            lq_ent_t     h;
            idle();
            v32   = ($urandom_range(0, 3) != 0);
            store = ($urandom_range(0, 3) == 0);
            f3    = store ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            sz    = 1 << f3[1:0];
            base  = $urandom & 32'hFFFFFFF0;
            off   = ($urandom_range(0, 3) != 0) ? (32'($urandom_range(0, 15)) & ~32'(sz - 1))
                                                : 32'($urandom_range(0, 15));
            wdata = 64'($urandom);
            rd    = 5'($urandom_range(0, 31));
            gnt   = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 19) == 0);
            rv32  = (mq.size() > 0) && ($urandom_range(0, 2) == 0);
            rdata = 64'($urandom);
            @(negedge clk);

            check("rand reg_we", regwe32, e_we);
            if (e_we) begin
                check("rand reg_waddr", wa32, e_wa);
                check("rand reg_wdata", wd32, e_wd);
            end
            check("rand exc_valid", exc32, e_exc);
            if (e_exc) begin
                check("rand exc_addr", exca32, e_exca);
                check("rand exc_store", excs32, e_excs);
            end
            check("rand busy", busy32, mq.size() != 0);

            ea  = base + off;
            sup = store ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
            mis = !sup || ((ea % sz) != 0);
            e_req = 0; e_rdy = 0;
            if (v32) begin
                if (flush || mis) e_rdy = 1;
                else if (store) begin e_req = 1; e_rdy = gnt; end
                else begin e_req = (mq.size() < 4); e_rdy = gnt && e_req; end
            end
            e_strb = 0; e_mwd = 0;
            if (e_req && store) begin
                ln = int'(ea % 4);
                for (int b = 0; b < 4; b++)
                    if (b >= ln && b < ln + sz) begin
                        e_strb[b] = 1'b1;
                        e_mwd[8*b +: 8] = wdata[8*(b-ln) +: 8];
                    end
            end
            check("rand req", req32, e_req);
            check("rand ready", rdy32, e_rdy);
            check("rand addr", addr32, e_req ? (ea & ~32'h3) : 32'h0);
            check("rand we", we32, e_req && store);
            check("rand wstrb", strb32, e_strb);
            check("rand wdata", mwd32, e_mwd);
            if (e_req && gnt)
                $display("rand %0d: %s f3=%0d ea=0x%0h rd=%0d", cyc, store ? "store" : "load", f3, ea, rd);

            e_exc = v32 && !flush && mis; e_exca = ea; e_excs = store;
            e_we = 0;
            if (rv32) begin
                h = mq.pop_front();
                if (!h.kill && !flush) begin
                    e_we = 1; e_wa = h.rd; e_wd = ref_load(rdata[31:0], h.f3, h.off);
                end
            end
            if (flush) foreach (mq[k]) mq[k].kill = 1;
            if (e_req && gnt && !store) mq.push_back('{rd, f3, ea[1:0], 1'b0});
            step();
        end
        idle();
        step();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
